// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//
// Purpose:
//   Consumer end of the 8-bit LFSR random stream. On request it turns
//   successive random bytes into a free (x,y) food cell on the snake
//   playfield. Candidate coordinates are the truncated low bits of
//   Random_Data and are rejected if they fall outside the grid. Each
//   in-range candidate is checked against the snake-body tracker with a
//   one-cycle occupancy query. After MAX_TRIES rejects the search is
//   exhausted.
//
// Configuration macro:
//   FALLBACK_SCAN_EN - when defined, exhaustion starts a raster scan from
//                      (0,0) that places food on the first free cell. When
//                      undefined, exhaustion pulses fail and returns to IDLE.
//
// Ports:
//   CLK          in   system clock, all logic on posedge
//   RESET        in   synchronous, active-high reset
//   Random_Data  in   [7:0] LFSR output, advances every CLK
//   spawn_req    in   request a new food cell (accepted only in IDLE)
//   occ_hit      in   occupancy answer, valid 1 cycle after query_valid
//   query_valid  out  1-cycle occupancy query strobe
//   query_x      out  [X_BITS-1:0] queried cell x (held through the wait)
//   query_y      out  [Y_BITS-1:0] queried cell y (held through the wait)
//   food_x       out  [X_BITS-1:0] current food x
//   food_y       out  [Y_BITS-1:0] current food y
//   food_valid   out  food_x/food_y hold a placed cell
//   busy         out  high in every state except IDLE
//   done         out  1-cycle pulse: new food placed
//   fail         out  1-cycle pulse: no free cell found
// -----------------------------------------------------------------------------
module food_spawner #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int X_BITS    = 6,
  parameter int Y_BITS    = 5,
  parameter int MAX_TRIES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        Random_Data,
  input  logic              spawn_req,
  input  logic              occ_hit,
  output logic              query_valid,
  output logic [X_BITS-1:0] query_x,
  output logic [Y_BITS-1:0] query_y,
  output logic [X_BITS-1:0] food_x,
  output logic [Y_BITS-1:0] food_y,
  output logic              food_valid,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  // Counter must be able to hold MAX_TRIES itself (value after the final reject).
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

`ifdef FALLBACK_SCAN_EN
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(GRID_H - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    DRAW_X,
    DRAW_Y,
    QUERY,
    WAIT,
    SCAN_Q,
    SCAN_W
  } state_t;

  state_t             state;
  logic [X_BITS-1:0]  cx;
  logic [Y_BITS-1:0]  cy;
  logic [TRY_W-1:0]   tries;

  logic [X_BITS-1:0]  rx;
  logic [Y_BITS-1:0]  ry;
  logic               x_ok;
  logic               y_ok;
  logic               reject;
  logic               last_try;
  logic               unused_rnd;

  // Coordinates are plain truncations of the random byte; the range check
  // is one bit wider so a grid exactly 2**BITS wide still compares correctly.
  assign rx   = Random_Data[X_BITS-1:0];
  assign ry   = Random_Data[Y_BITS-1:0];
  assign x_ok = {1'b0, rx} < (X_BITS+1)'(GRID_W);
  assign y_ok = {1'b0, ry} < (Y_BITS+1)'(GRID_H);

  // Upper random bits are intentionally discarded.
  assign unused_rnd = ^Random_Data;

  // A reject is an out-of-range draw or an occupied candidate. The reject
  // that brings the counter to MAX_TRIES is the one that exhausts the search.
  assign reject   = ((state == DRAW_X) && !x_ok) ||
                    ((state == DRAW_Y) && !y_ok) ||
                    ((state == WAIT)   && occ_hit);
  assign last_try = (tries == TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cx          <= '0;
      cy          <= '0;
      tries       <= '0;
      query_valid <= 1'b0;
      query_x     <= '0;
      query_y     <= '0;
      food_x      <= '0;
      food_y      <= '0;
      food_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      done        <= 1'b0;
      fail        <= 1'b0;
      query_valid <= 1'b0;

      if (reject) begin
        tries <= tries + TRY_W'(1);
      end

      if (reject && last_try) begin
`ifdef FALLBACK_SCAN_EN
        // Random search gave up: fall back to an exhaustive raster scan.
        state       <= SCAN_Q;
        cx          <= '0;
        cy          <= '0;
        query_valid <= 1'b1;
        query_x     <= '0;
        query_y     <= '0;
`else
        state <= IDLE;
        busy  <= 1'b0;
        fail  <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (spawn_req) begin
              state      <= DRAW_X;
              busy       <= 1'b1;
              food_valid <= 1'b0;
              tries      <= '0;
            end
          end

          DRAW_X: begin
            cx <= rx;
            if (x_ok) begin
              state <= DRAW_Y;
            end
          end

          // The query strobe is launched on the same edge the y draw lands,
          // so the tracker sees it during the QUERY cycle.
          DRAW_Y: begin
            cy <= ry;
            if (y_ok) begin
              state       <= QUERY;
              query_valid <= 1'b1;
              query_x     <= cx;
              query_y     <= ry;
            end
          end

          QUERY: begin
            state <= WAIT;
          end

          WAIT: begin
            if (!occ_hit) begin
              food_x     <= cx;
              food_y     <= cy;
              food_valid <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= DRAW_X;
            end
          end

`ifdef FALLBACK_SCAN_EN
          SCAN_Q: begin
            state <= SCAN_W;
          end

          SCAN_W: begin
            if (!occ_hit) begin
              food_x     <= cx;
              food_y     <= cy;
              food_valid <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if ((cx == X_LAST) && (cy == Y_LAST)) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // Raster order: x first, wrapping to the next row.
              if (cx == X_LAST) begin
                cx      <= '0;
                cy      <= cy + Y_BITS'(1);
                query_x <= '0;
                query_y <= cy + Y_BITS'(1);
              end else begin
                cx      <= cx + X_BITS'(1);
                query_x <= cx + X_BITS'(1);
              end
              query_valid <= 1'b1;
              state       <= SCAN_Q;
            end
          end
`endif

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
